// File: rtl/servant_uart_pkg.sv
// rtl/servant_uart_pkg.sv - shared types and constants for the servant UART transmitter
package servant_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;

endpackage

// File: rtl/servant_uart_fifo.sv
// rtl/servant_uart_fifo.sv - transmit byte buffer; SERVANT_UART_FIFO_EN selects a DEPTH-entry
// circular FIFO, otherwise a single holding register
module servant_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

`ifdef SERVANT_UART_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // The extra pointer bit separates full (same slot, different lap) from empty.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       unused_depth;

  assign unused_depth = (DEPTH != 0);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push) begin
      data_d  = push_data;
      valid_d = 1'b1;
    end
  end

  assign full     = valid_q;
  assign empty    = ~valid_q;
  assign pop_data = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: rtl/servant_uart_tx.sv
// rtl/servant_uart_tx.sv - Wishbone-slave 8N1 UART transmitter; buffer depth chosen by
// SERVANT_UART_FIFO_EN
module servant_uart_tx
  import servant_uart_pkg::*;
#(
  parameter int CLK_DIV    = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_uart_txd
);

  localparam int             DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;

  logic       req, wr_is_data, push, pop, full, empty, div_wrap, txd;
  logic [7:0] head;
  logic       unused_dat_hi;

  assign unused_dat_hi = ^i_wb_dat[31:8];

  servant_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .push     (push),
    .push_data(i_wb_dat[7:0]),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  // The cycle after an ack never starts a new transfer, so a late-dropping cyc is harmless.
  assign req        = i_wb_cyc & ~ack_q;
  assign wr_is_data = i_wb_we & (i_wb_adr == ADR_DATA);
  assign div_wrap   = (div_q == DIV_LAST);
  assign pop        = ~empty & ((state_q == IDLE) | ((state_q == STOP) & div_wrap));
  assign push       = req & wr_is_data & (~full | pop);

  always_comb begin
    ack_d = req & (~wr_is_data | push);
    rdt_d = '0;
    if (req & ~i_wb_we & (i_wb_adr == ADR_STATUS)) begin
      rdt_d[ST_FULL]  = full;
      rdt_d[ST_EMPTY] = empty;
      rdt_d[ST_BUSY]  = (state_q != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd     = 1'b1;
    if (state_q != IDLE) begin
      div_d = div_wrap ? '0 : div_q + DW'(1);
    end
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (div_wrap) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd = shift_q[0];
        if (div_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (div_wrap) begin
          if (!empty) begin
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_rdt   = rdt_q;
  assign o_uart_txd = txd;

endmodule

// File: tb/tb_servant_uart_tx.sv
// tb/tb_servant_uart_tx.sv - scoreboard bench for servant_uart_tx with a frame-level reference model
module tb_servant_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;
`ifdef SERVANT_UART_FIFO_EN
  localparam int MDEPTH = FIFO_DEPTH;
`else
  localparam int MDEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic        adr = 1'b0;
  logic [31:0] dat = '0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_uart_txd;

  servant_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .wb_clk    (clk),
    .wb_rst    (rst),
    .i_wb_cyc  (cyc),
    .i_wb_we   (we),
    .i_wb_adr  (adr),
    .i_wb_dat  (dat),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .o_uart_txd(o_uart_txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rdt;
  } resp_t;
  typedef struct {
    int         cyc;
    logic [7:0] b;
  } frame_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc_cnt = 0;
  logic   mon_en = 1'b0;
  logic   rst_seen = 1'b1;

  // reference model: buffered bytes, cycles left in the frame on the wire, pending ack
  logic [7:0] m_q[$];
  int         m_left = 0;
  logic       m_ack = 1'b0;
  resp_t      resp_q[$];
  frame_t     frame_q[$];

  // line monitor state
  logic       in_frame = 1'b0;
  int         pos = 0;
  logic       frame_ok;
  logic [7:0] fb;
  logic [7:0] rx_byte;
  int         last_end = -10;
  int         contig = 0;
  int         nframes = 0;

  logic [7:0] burst [5] = '{8'h55, 8'h0F, 8'hF0, 8'h33, 8'hC3};

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  initial forever begin
    logic        req, pop, acc;
    logic [31:0] st;
    @(posedge clk);
    rst_seen = rst;
    if (rst) begin
      m_q.delete();
      frame_q.delete();
      m_left = 0;
      m_ack  = 1'b0;
    end else begin
      req = cyc && !m_ack;
      st  = {29'b0, m_q.size() == MDEPTH, m_q.size() == 0, m_left != 0};
      pop = (m_q.size() != 0) && (m_left <= 1);
      acc = req && we && (adr == 1'b0) && ((m_q.size() < MDEPTH) || pop);
      if (pop) begin
        frame_q.push_back('{cyc_cnt + 1, m_q.pop_front()});
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (acc) m_q.push_back(dat[7:0]);
      m_ack = req && (!(we && adr == 1'b0) || acc);
      if (m_ack) resp_q.push_back('{cyc_cnt + 1, (!we && adr) ? st : 32'h0});
    end
    cyc_cnt++;
  end

  initial forever begin
    resp_t  r;
    frame_t f;
    int     k;
    logic   exp_bit;
    @(negedge clk);
    if (mon_en) begin
      if (o_wb_ack === 1'b1) begin
        if (resp_q.size() == 0) begin
          check(1'b0, "unexpected_ack", 32'(cyc_cnt), 32'h0);
        end else begin
          r = resp_q.pop_front();
          check(r.cyc == cyc_cnt, "ack_cycle", 32'(cyc_cnt), 32'(r.cyc));
          check(o_wb_rdt === r.rdt, "read_data", o_wb_rdt, r.rdt);
        end
      end else begin
        check(o_wb_rdt === 32'h0, "rdt_without_ack", o_wb_rdt, 32'h0);
        if (resp_q.size() != 0 && resp_q[0].cyc <= cyc_cnt) begin
          r = resp_q.pop_front();
          check(1'b0, "missing_ack", 32'(cyc_cnt), 32'(r.cyc));
        end
      end
      if (rst_seen) in_frame = 1'b0;
      if (!in_frame && o_uart_txd !== 1'b1) begin
        frame_ok = 1'b1;
        if (frame_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 32'(cyc_cnt), 32'h0);
          fb       = 8'h00;
          frame_ok = 1'b0;
        end else begin
          f = frame_q.pop_front();
          check(f.cyc == cyc_cnt, "frame_start", 32'(cyc_cnt), 32'(f.cyc));
          fb = f.b;
        end
        if (cyc_cnt == last_end + 1) contig++;
        in_frame = 1'b1;
        pos      = 0;
        rx_byte  = 8'h00;
      end
      if (in_frame) begin
        k       = pos / CLK_DIV;
        exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[k-1];
        if (o_uart_txd !== exp_bit) frame_ok = 1'b0;
        if (k >= 1 && k <= 8 && (pos % CLK_DIV) == CLK_DIV / 2) rx_byte[k-1] = o_uart_txd;
        pos++;
        if (pos == FRAME) begin
          check(frame_ok, "frame_wave", {24'h0, rx_byte}, {24'h0, fb});
          in_frame = 1'b0;
          last_end = cyc_cnt;
          nframes++;
        end
      end
    end
  end

  task automatic wb_access(input logic w, input logic a, input logic [31:0] d, input bit hold,
                           output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1;
    we  = w;
    adr = a;
    dat = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_wb_ack !== 1'b1 && lat < 1000);
    check(o_wb_ack === 1'b1, "ack_seen", 32'(lat), 32'd1000);
    rd = o_wb_rdt;
    if (hold) @(negedge clk);
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((frame_q.size() != 0 || in_frame || m_left != 0 || m_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(n < maxc, "drain_bound", 32'(n), 32'(maxc));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] wd;
    int          lat, n, base, sel;
    bit          hold;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    check(o_uart_txd === 1'b1, "reset_txd", {31'h0, o_uart_txd}, 32'h1);
    check(o_wb_ack === 1'b0, "reset_ack", {31'h0, o_wb_ack}, 32'h0);
    check(o_wb_rdt === 32'h0, "reset_rdt", o_wb_rdt, 32'h0);

    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_uart_txd !== 1'b1 || o_wb_ack !== 1'b0) n++;
    end
    check(n == 0, "idle_quiet", 32'(n), 32'h0);
    wb_access(1'b0, 1'b1, 32'h0, 1'b0, rd, lat);
    check(rd === 32'h2, "idle_status", rd, 32'h2);

    base = nframes;
    wb_access(1'b1, 1'b0, 32'hFFFF_FFA5, 1'b0, rd, lat);
    check(lat == 1, "write_latency", 32'(lat), 32'h1);
    wait_drain(200);
    check(nframes - base == 1, "a5_frame_count", 32'(nframes - base), 32'h1);

    base = contig;
    for (int i = 0; i < 5; i++) begin
      wb_access(1'b1, 1'b0, {24'h0, burst[i]}, 1'b0, rd, lat);
      if (i == 0) check(lat == 1, "burst_first_latency", 32'(lat), 32'h1);
    end
    wb_access(1'b0, 1'b1, 32'h0, 1'b0, rd, lat);
    wait_drain(600);
    check(contig - base == 4, "burst_contiguous", 32'(contig - base), 32'h4);

    wb_access(1'b1, 1'b0, 32'h11, 1'b0, rd, lat);
    wb_access(1'b1, 1'b0, 32'h22, 1'b0, rd, lat);
    wb_access(1'b1, 1'b0, 32'h33, 1'b0, rd, lat);
    repeat (10) @(negedge clk);
    wb_access(1'b0, 1'b1, 32'h0, 1'b0, rd, lat);
    check(rd[0] === 1'b1, "busy_midframe", rd, 32'h1);
    wait_drain(400);

    wb_access(1'b1, 1'b0, 32'hFF, 1'b0, rd, lat);
    wb_access(1'b1, 1'b0, 32'h01, 1'b0, rd, lat);
    if (MDEPTH > 1) wb_access(1'b1, 1'b0, 32'h02, 1'b0, rd, lat);
    n = 0;
    while (!(in_frame && pos >= 4 * CLK_DIV && pos < 5 * CLK_DIV - 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(n < 200, "reach_bit3", 32'(n), 32'd200);
    base = nframes;
    rst  = 1'b1;
    @(negedge clk);
    check(o_uart_txd === 1'b1, "txd_after_rst", {31'h0, o_uart_txd}, 32'h1);
    rst = 1'b0;
    wb_access(1'b0, 1'b1, 32'h0, 1'b0, rd, lat);
    check(rd === 32'h2, "status_after_rst", rd, 32'h2);
    repeat (120) @(negedge clk);
    check(nframes == base, "no_frames_after_rst", 32'(nframes), 32'(base));

    base = nframes;
    wb_access(1'b1, 1'b0, 32'h3C, 1'b1, rd, lat);
    wait_drain(200);
    check(nframes - base == 1, "late_cyc_single_frame", 32'(nframes - base), 32'h1);

    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 9));
      hold = ($urandom_range(0, 3) == 0);
      wd   = $urandom;
      if (sel <= 5)      wb_access(1'b1, 1'b0, wd, hold, rd, lat);
      else if (sel <= 7) wb_access(1'b0, 1'b1, wd, hold, rd, lat);
      else if (sel == 8) wb_access(1'b1, 1'b1, wd, hold, rd, lat);
      else               wb_access(1'b0, 1'b0, wd, hold, rd, lat);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_drain(4000);
    repeat (5) @(negedge clk);
    check(resp_q.size() == 0, "responses_drained", 32'(resp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
